// File: rtl/rob_multi_pkg.sv
// rob_multi shared types and constants.
// Parameter-independent encodings used by the ROB and its neighbours.
package rob_multi_pkg;

    localparam int DEF_DEPTH    = 8;
    localparam int DEF_NUM_CDB  = 2;
    localparam int DEF_COMMIT_W = 2;
    localparam int DEF_DATA_W   = 16;
    localparam int DEF_REG_W    = 4;

    // Destination id 0 means the instruction writes no register.
    localparam logic [DEF_REG_W-1:0] REG_NONE = '0;

    // One completion broadcast at the default widths.
    typedef struct packed {
        logic                          valid;
        logic                          redirect;
        logic [$clog2(DEF_DEPTH)-1:0]  tag;
        logic [DEF_DATA_W-1:0]         value;
        logic [DEF_DATA_W-1:0]         target;
    } cdb_port_t;

endpackage

// File: rtl/rob_multi_if.sv
// rob_multi bus: allocate handshake, CDB completion ports,
// and commit/redirect outputs.
interface rob_multi_if
    import rob_multi_pkg::*;
#(
    parameter int DEPTH    = DEF_DEPTH,
    parameter int NUM_CDB  = DEF_NUM_CDB,
    parameter int COMMIT_W = DEF_COMMIT_W,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int REG_W    = DEF_REG_W
);
    localparam int IDX_W = $clog2(DEPTH);

    logic                         alloc_valid;
    logic                         alloc_ready;
    logic [REG_W-1:0]             alloc_reg;
    logic [IDX_W-1:0]             alloc_tag;

    logic [NUM_CDB-1:0]           cdb_valid;
    logic [NUM_CDB*IDX_W-1:0]     cdb_tag;
    logic [NUM_CDB*DATA_W-1:0]    cdb_value;
    logic [NUM_CDB-1:0]           cdb_redirect;
    logic [NUM_CDB*DATA_W-1:0]    cdb_target;

    logic [COMMIT_W-1:0]          commit_valid;
    logic [COMMIT_W*REG_W-1:0]    commit_reg;
    logic [COMMIT_W*DATA_W-1:0]   commit_value;
    logic [COMMIT_W*IDX_W-1:0]    commit_tag;
    logic                         redirect_valid;
    logic [DATA_W-1:0]            redirect_pc;

    logic [IDX_W:0]               count;
    logic                         empty;
    logic                         full;

    // ROB side
    modport slave (
        input  alloc_valid, alloc_reg,
        input  cdb_valid, cdb_tag, cdb_value, cdb_redirect, cdb_target,
        output alloc_ready, alloc_tag,
        output commit_valid, commit_reg, commit_value, commit_tag,
        output redirect_valid, redirect_pc,
        output count, empty, full
    );

    // Dispatch / CDB / retire side
    modport master (
        output alloc_valid, alloc_reg,
        output cdb_valid, cdb_tag, cdb_value, cdb_redirect, cdb_target,
        input  alloc_ready, alloc_tag,
        input  commit_valid, commit_reg, commit_value, commit_tag,
        input  redirect_valid, redirect_pc,
        input  count, empty, full
    );

endinterface

// File: rtl/rob_multi_commit_select.sv
// Prefix select over the commit window: contiguous ready lanes,
// stopping after the first redirect or at the occupancy limit.
module rob_commit_select #(
    parameter int COMMIT_W = 2,
    parameter int CNT_W    = 4,
    parameter int LANE_W   = (COMMIT_W > 1) ? $clog2(COMMIT_W) : 1
) (
    input  logic [COMMIT_W-1:0] win_busy,
    input  logic [COMMIT_W-1:0] win_done,
    input  logic [COMMIT_W-1:0] win_redir,
    input  logic [CNT_W-1:0]    count,
    output logic [COMMIT_W-1:0] lane_valid,
    output logic [CNT_W-1:0]    k,
    output logic                redir_any,
    output logic [LANE_W-1:0]   redir_lane
);

    // Walk lanes in order; the first blocked lane ends the prefix.
    always_comb begin
        logic go;
        lane_valid = '0;
        k          = '0;
        redir_any  = 1'b0;
        redir_lane = '0;
        go         = 1'b1;
        for (int i = 0; i < COMMIT_W; i++) begin
            if (go && win_busy[i] && win_done[i] && (CNT_W'(i) < count)) begin
                lane_valid[i] = 1'b1;
                k             = k + CNT_W'(1);
                if (win_redir[i]) begin
                    redir_any  = 1'b1;
                    redir_lane = LANE_W'(i);
                    go         = 1'b0;
                end
            end else begin
                go = 1'b0;
            end
        end
    end

endmodule

// File: rtl/rob_multi.sv
// Multi-port reorder buffer: circular in-order queue with NUM_CDB
// completion ports, COMMIT_W-wide retirement and redirect squash.
module rob_multi
    import rob_multi_pkg::*;
#(
    parameter int DEPTH    = DEF_DEPTH,
    parameter int NUM_CDB  = DEF_NUM_CDB,
    parameter int COMMIT_W = DEF_COMMIT_W,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int REG_W    = DEF_REG_W
) (
    input  logic      clk,
    input  logic      reset,
    rob_multi_if.slave bus
);
    localparam int IDX_W  = $clog2(DEPTH);
    localparam int CNT_W  = IDX_W + 1;
    localparam int LANE_W = (COMMIT_W > 1) ? $clog2(COMMIT_W) : 1;

    typedef struct packed {
        logic              busy;
        logic              done;
        logic              redirect;
        logic [REG_W-1:0]  rd;
        logic [DATA_W-1:0] value;
        logic [DATA_W-1:0] target;
    } entry_t;

    entry_t            ents_q [DEPTH];
    entry_t            ents_d [DEPTH];
    logic [IDX_W-1:0]  head_q, head_d;
    logic [IDX_W-1:0]  tail_q, tail_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              squash_q, squash_d;

    logic [IDX_W-1:0]  widx [COMMIT_W];
    logic [COMMIT_W-1:0] win_busy, win_done, win_redir;
    logic [COMMIT_W-1:0] lane_valid;
    logic [CNT_W-1:0]  k;
    logic              redir_any;
    logic [LANE_W-1:0] redir_lane;
    logic              full_w;
    logic              alloc_fire;

    // Gather the commit window starting at head.
    always_comb begin
        for (int i = 0; i < COMMIT_W; i++) begin
            widx[i]      = head_q + IDX_W'(i);
            win_busy[i]  = ents_q[widx[i]].busy;
            win_done[i]  = ents_q[widx[i]].done;
            win_redir[i] = ents_q[widx[i]].redirect;
        end
    end

    rob_commit_select #(
        .COMMIT_W (COMMIT_W),
        .CNT_W    (CNT_W),
        .LANE_W   (LANE_W)
    ) u_sel (
        .win_busy   (win_busy),
        .win_done   (win_done),
        .win_redir  (win_redir),
        .count      (count_q),
        .lane_valid (lane_valid),
        .k          (k),
        .redir_any  (redir_any),
        .redir_lane (redir_lane)
    );

    // Status, handshake and commit-lane outputs from registered state.
    always_comb begin
        full_w             = (count_q == CNT_W'(DEPTH));
        bus.full           = full_w;
        bus.empty          = (count_q == '0);
        bus.count          = count_q;
        bus.alloc_ready    = !full_w && !squash_q;
        bus.alloc_tag      = tail_q;
        alloc_fire         = bus.alloc_valid && !full_w && !squash_q;
        bus.commit_valid   = lane_valid;
        bus.commit_reg     = '0;
        bus.commit_value   = '0;
        bus.commit_tag     = '0;
        bus.redirect_valid = redir_any;
        bus.redirect_pc    = '0;
        for (int i = 0; i < COMMIT_W; i++) begin
            bus.commit_reg[i*REG_W +: REG_W]    = ents_q[widx[i]].rd;
            bus.commit_value[i*DATA_W +: DATA_W] = ents_q[widx[i]].value;
            bus.commit_tag[i*IDX_W +: IDX_W]    = widx[i];
            if (redir_any && (redir_lane == LANE_W'(i))) begin
                bus.redirect_pc = ents_q[widx[i]].target;
            end
        end
    end

    // Next state: complete, retire, allocate; a redirect overrides all.
    always_comb begin
        logic [IDX_W-1:0] t;
        t = '0;
        for (int e = 0; e < DEPTH; e++) begin
            ents_d[e] = ents_q[e];
        end
        head_d   = head_q + k[IDX_W-1:0];
        tail_d   = tail_q;
        count_d  = count_q + CNT_W'(alloc_fire) - k;
        squash_d = 1'b0;

        // Highest port first so the lowest port's write lands last.
        for (int p = NUM_CDB - 1; p >= 0; p--) begin
            t = bus.cdb_tag[p*IDX_W +: IDX_W];
            if (bus.cdb_valid[p] && ents_q[t].busy) begin
                ents_d[t].done     = 1'b1;
                ents_d[t].value    = bus.cdb_value[p*DATA_W +: DATA_W];
                ents_d[t].redirect = bus.cdb_redirect[p];
                ents_d[t].target   = bus.cdb_target[p*DATA_W +: DATA_W];
            end
        end

        for (int i = 0; i < COMMIT_W; i++) begin
            if (lane_valid[i]) begin
                ents_d[widx[i]] = '0;
            end
        end

        if (alloc_fire) begin
            ents_d[tail_q]      = '0;
            ents_d[tail_q].busy = 1'b1;
            ents_d[tail_q].rd   = bus.alloc_reg;
            tail_d              = tail_q + IDX_W'(1);
        end

        if (redir_any) begin
            for (int e = 0; e < DEPTH; e++) begin
                ents_d[e] = '0;
            end
            head_d   = '0;
            tail_d   = '0;
            count_d  = '0;
            squash_d = 1'b1;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int e = 0; e < DEPTH; e++) begin
                ents_q[e] <= '0;
            end
            head_q   <= '0;
            tail_q   <= '0;
            count_q  <= '0;
            squash_q <= 1'b0;
        end else begin
            for (int e = 0; e < DEPTH; e++) begin
                ents_q[e] <= ents_d[e];
            end
            head_q   <= head_d;
            tail_q   <= tail_d;
            count_q  <= count_d;
            squash_q <= squash_d;
        end
    end

endmodule

// File: tb/tb_rob_multi.sv
// Directed bench for rob_multi: allocate/full, out-of-order completion,
// same-tag port priority, head wrap, redirect squash, mid-run reset.
module tb_rob_multi;

    logic clk;
    logic reset;
    int   n_tests;
    int   n_fail;

    rob_multi_if bus ();

    rob_multi dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cdb_off();
        bus.cdb_valid    = '0;
        bus.cdb_tag      = '0;
        bus.cdb_value    = '0;
        bus.cdb_redirect = '0;
        bus.cdb_target   = '0;
    endtask

    initial begin
        int nxt;
        int expt;
        int ncommit;
        n_tests = 0;
        n_fail  = 0;
        reset   = 1'b1;
        bus.alloc_valid = 1'b0;
        bus.alloc_reg   = '0;
        cdb_off();

        // Reset
        step();
        step();
        reset = 1'b0;
        chk("rst_ready", 32'(bus.alloc_ready), 1);
        chk("rst_cv", 32'(bus.commit_valid), 0);
        chk("rst_rv", 32'(bus.redirect_valid), 0);
        chk("rst_empty", 32'(bus.empty), 1);
        chk("rst_full", 32'(bus.full), 0);
        chk("rst_tag", 32'(bus.alloc_tag), 0);
        chk("rst_count", 32'(bus.count), 0);

        // Allocate 8, regs 1..8
        for (int i = 0; i < 8; i++) begin
            bus.alloc_valid = 1'b1;
            bus.alloc_reg   = 4'(i + 1);
            chk("alloc_tag", 32'(bus.alloc_tag), 32'(i));
            step();
        end
        bus.alloc_valid = 1'b0;
        chk("fill_full", 32'(bus.full), 1);
        chk("fill_ready", 32'(bus.alloc_ready), 0);
        chk("fill_count", 32'(bus.count), 8);
        chk("fill_cv", 32'(bus.commit_valid), 0);

        // Complete tag 1 then tag 0
        bus.cdb_valid = 2'b01;
        bus.cdb_tag   = {3'd0, 3'd1};
        bus.cdb_value = {16'h0, 16'h0011};
        step();
        cdb_off();
        chk("ooo_nocommit", 32'(bus.commit_valid), 0);
        bus.cdb_valid = 2'b01;
        bus.cdb_tag   = {3'd0, 3'd0};
        bus.cdb_value = {16'h0, 16'h0022};
        step();
        cdb_off();
        chk("ooo_cv", 32'(bus.commit_valid), 32'h3);
        chk("ooo_val0", 32'(bus.commit_value[15:0]), 32'h22);
        chk("ooo_val1", 32'(bus.commit_value[31:16]), 32'h11);
        chk("ooo_reg0", 32'(bus.commit_reg[3:0]), 1);
        chk("ooo_reg1", 32'(bus.commit_reg[7:4]), 2);
        chk("ooo_tag1", 32'(bus.commit_tag[5:3]), 1);
        step();
        chk("ooo_count", 32'(bus.count), 6);
        chk("ooo_ready", 32'(bus.alloc_ready), 1);

        // Same tag on both ports: port 0 wins
        bus.cdb_valid = 2'b11;
        bus.cdb_tag   = {3'd3, 3'd3};
        bus.cdb_value = {16'h00BB, 16'h00AA};
        step();
        bus.cdb_valid = 2'b01;
        bus.cdb_tag   = {3'd0, 3'd2};
        bus.cdb_value = {16'h0, 16'h0033};
        step();
        cdb_off();
        chk("dup_cv", 32'(bus.commit_valid), 32'h3);
        chk("dup_val0", 32'(bus.commit_value[15:0]), 32'h33);
        chk("dup_val1", 32'(bus.commit_value[31:16]), 32'hAA);
        step();
        chk("dup_count", 32'(bus.count), 4);

        // Refill, then run across the head wrap
        for (int i = 0; i < 4; i++) begin
            bus.alloc_valid = 1'b1;
            bus.alloc_reg   = 4'(i + 9);
            chk("refill_tag", 32'(bus.alloc_tag), 32'(i));
            step();
        end
        chk("refill_full", 32'(bus.full), 1);
        nxt     = 4;
        expt    = 4;
        ncommit = 0;
        for (int c = 0; c < 20; c++) begin
            chk("wrap_le8", 32'(bus.count <= 4'd8), 1);
            if (bus.commit_valid[0]) begin
                chk("wrap_tag", 32'(bus.commit_tag[2:0]), 32'(expt));
                chk("wrap_one", 32'(bus.commit_valid[1]), 0);
                expt = (expt + 1) % 8;
                ncommit++;
            end
            bus.alloc_valid = 1'b1;
            bus.cdb_valid   = 2'b01;
            bus.cdb_tag     = {3'd0, 3'(nxt)};
            bus.cdb_value   = {16'h0, 16'(16'h100 + c)};
            nxt = (nxt + 1) % 8;
            step();
        end
        chk("wrap_ncommit", 32'(ncommit), 19);
        chk("wrap_count", 32'(bus.count), 7);

        // Reset mid-run with a strobe active
        bus.alloc_valid = 1'b0;
        bus.cdb_valid   = 2'b01;
        bus.cdb_tag     = {3'd0, 3'd0};
        bus.cdb_value   = {16'h0, 16'h0055};
        reset = 1'b1;
        step();
        reset = 1'b0;
        cdb_off();
        chk("mrst_count", 32'(bus.count), 0);
        chk("mrst_cv", 32'(bus.commit_valid), 0);
        chk("mrst_empty", 32'(bus.empty), 1);
        bus.alloc_valid = 1'b1;
        bus.alloc_reg   = 4'd5;
        step();
        bus.alloc_valid = 1'b0;
        chk("mrst_lost", 32'(bus.commit_valid), 0);
        chk("mrst_cnt1", 32'(bus.count), 1);

        // Redirect: tags 0..4, 3/4 done early, 2 redirects
        for (int i = 1; i < 5; i++) begin
            bus.alloc_valid = 1'b1;
            bus.alloc_reg   = 4'(i);
            step();
        end
        bus.alloc_valid = 1'b0;
        chk("rd_count5", 32'(bus.count), 5);
        bus.cdb_valid = 2'b11;
        bus.cdb_tag   = {3'd4, 3'd3};
        bus.cdb_value = {16'h0044, 16'h0033};
        step();
        bus.cdb_tag   = {3'd1, 3'd0};
        bus.cdb_value = {16'h0011, 16'h0010};
        step();
        chk("rd_pre_cv", 32'(bus.commit_valid), 32'h3);
        chk("rd_pre_rv", 32'(bus.redirect_valid), 0);
        bus.cdb_valid    = 2'b01;
        bus.cdb_tag      = {3'd0, 3'd2};
        bus.cdb_value    = {16'h0, 16'h0022};
        bus.cdb_redirect = 2'b01;
        bus.cdb_target   = {16'h0, 16'h3000};
        step();
        cdb_off();
        bus.alloc_valid = 1'b1;
        chk("rd_cv", 32'(bus.commit_valid), 32'h1);
        chk("rd_tag", 32'(bus.commit_tag[2:0]), 2);
        chk("rd_rv", 32'(bus.redirect_valid), 1);
        chk("rd_pc", 32'(bus.redirect_pc), 32'h3000);
        step();
        bus.alloc_valid = 1'b0;
        chk("rd_count0", 32'(bus.count), 0);
        chk("rd_ready0", 32'(bus.alloc_ready), 0);
        chk("rd_cv0", 32'(bus.commit_valid), 0);
        chk("rd_rv0", 32'(bus.redirect_valid), 0);
        step();
        chk("rd_ready1", 32'(bus.alloc_ready), 1);
        chk("rd_tag0", 32'(bus.alloc_tag), 0);
        chk("rd_empty", 32'(bus.empty), 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/rob_multi.md
Name: rob_multi

Overview:
Parametrised successor to the single-issue reorder buffer in the lc3b Tomasulo core. It is a circular in-order queue with an explicit allocate handshake, NUM_CDB independent completion (broadcast) ports, and up to COMMIT_W in-order retirements per cycle. A committing entry that carries a PC redirect squashes all younger entries and drives the new PC to fetch. It sits between dispatch (allocate), the reservation stations/CDB arbiter (complete), and the register file plus fetch (commit/redirect).

Parameters:
DEPTH, 8, number of entries; power of two, minimum 4
IDX_W, $clog2(DEPTH), entry tag width
NUM_CDB, 2, number of completion ports
COMMIT_W, 2, maximum retirements per cycle; 1 <= COMMIT_W <= DEPTH
DATA_W, 16, result and PC width
REG_W, 4, extended destination register id width; value 0 means "no register write"

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
alloc_valid  in  1  dispatch requests an entry
alloc_ready  out  1  entry available; a transfer occurs when valid && ready
alloc_reg  in  REG_W  destination register of the allocated instruction
alloc_tag  out  IDX_W  tag the next transfer receives (the current tail)
cdb_valid  in  NUM_CDB  completion strobe for each port
cdb_tag  in  NUM_CDB*IDX_W  entry completed on each port
cdb_value  in  NUM_CDB*DATA_W  result on each port
cdb_redirect  in  NUM_CDB  the entry must redirect the PC when it commits
cdb_target  in  NUM_CDB*DATA_W  redirect PC on each port
commit_valid  out  COMMIT_W  lane i retires this cycle; always a contiguous prefix (lane 0 first)
commit_reg  out  COMMIT_W*REG_W  destination register per lane
commit_value  out  COMMIT_W*DATA_W  result per lane
commit_tag  out  COMMIT_W*IDX_W  retiring tag per lane
redirect_valid  out  1  a committing lane carries a redirect
redirect_pc  out  DATA_W  new fetch PC
count  out  IDX_W+1  number of occupied entries
empty  out  1  count == 0
full  out  1  count == DEPTH

Behaviour:
- State: head, tail, count, squash_pending; per entry: busy, done, redirect, reg, value, target.
- Reset (clk edge with reset high): head=tail=count=0, all entry fields cleared, squash_pending=0. Outputs then read alloc_ready=1, commit_valid=0, redirect_valid=0, empty=1, full=0, alloc_tag=0.
- alloc_ready = !full && !squash_pending. Full is computed from the registered count, so a commit in the same cycle does not free a slot for that cycle's allocate.
- Allocate: entry[tail] gets busy=1, done=0, redirect=0, reg=alloc_reg. tail = tail+1 mod DEPTH.
- Complete: for each port p with cdb_valid[p] set and entry[tag].busy set, write done=1, value, redirect, and target. A strobe to a non-busy entry is ignored. If two ports carry the same tag, the lower port index wins.
- Commit selection is combinational from registered state:
  - Lane i is valid iff lanes 0..i-1 are valid, entry[head+i] is busy && done, i < count, and no lower lane carries a redirect.
  - Retirement stops after the first redirect entry.
- Commit update: retired entries are cleared. head advances by k (mod DEPTH, wrap-around safe). count = count + alloc_fire - k.
- Redirect: when lane j carries a redirect, redirect_valid=1 and redirect_pc=target of that entry in the same cycle. On that edge:
  - all entries are cleared, head=tail=0, count=0;
  - that cycle's allocate and CDB writes are discarded;
  - squash_pending is set for one cycle, which holds alloc_ready low while fetch restarts.
- Simultaneous allocate, complete, and commit in one cycle are all legal. An allocate cannot target an entry that is being completed, because completion requires busy.
- Latency: a CDB write at cycle n can be committed at cycle n+1 at the earliest.

Decomposition:
- lc3b_types gains the parameter-independent constants (the REG_W "no write" encoding, default DEPTH) and a cdb port typedef.
- The entry struct is declared locally in the module because it depends on the parameters.
- One sub-module, rob_commit_select: a purely combinational prefix-select over COMMIT_W window entries that returns the lane valids, k, and the redirect lane.

Test Plan:
- Reset, then allocate 8 with alloc_reg=1..8 -> alloc_tag 0..7; full=1 and alloc_ready=0 after the 8th; count=8.
- Complete tags 1 then 0 (values 0x11, 0x22) -> no commit until tag 0 completes; next cycle commit_valid=2'b11 with values 0x22, 0x11 in order; count drops by 2.
- Complete tags 3 and 3 on both ports in the same cycle (0xAA on port 0, 0xBB on port 1) -> committed value 0xAA.
- Fill the buffer, then allocate and commit across head wrap 7->0 over 20 cycles -> tags retire strictly in order and count never exceeds 8.
- Tag 2 completes with redirect=1 and target 0x3000, tags 3 and 4 already done -> the commit cycle retires only up to tag 2, redirect_valid=1, redirect_pc=0x3000; next cycle count=0, alloc_ready=0; the cycle after that alloc_ready=1.
- Assert reset in the middle of a partially filled buffer with a CDB strobe active -> the next cycle shows count=0, commit_valid=0, and the strobe is lost.
